// File: rtl/clk_div_controller.sv
// Programmable 50%-duty clock divider with a ready/valid divisor port.
// New divisors requested while running take effect only at a clk_out falling edge.
module clk_div_controller #(
   parameter int DEF_DIV = 4,
   parameter int DIV_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [DIV_W-1:0] cur_div
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_PEND = 2'd2;
   localparam logic [1:0] S_STOP = 2'd3;

   logic [1:0]       state;
   logic [DIV_W-2:0] cnt;
   logic [DIV_W-1:0] pend_div;
   logic             hs, div_ok, terminal, boundary;

   assign cfg_ready = (state == S_IDLE) || (state == S_RUN);
   assign busy      = (state != S_IDLE);
   assign hs        = cfg_valid && cfg_ready;
   assign div_ok    = !cfg_div[0] && (cfg_div >= DIV_W'(2));
   assign terminal  = ({1'b0, cnt} == ((cur_div >> 1) - DIV_W'(1)));
   // A period ends on the falling edge of clk_out.
   assign boundary  = terminal && clk_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
         cfg_err  <= 1'b0;
         cur_div  <= DIV_W'(DEF_DIV);
         pend_div <= '0;
      end else begin
         tick    <= 1'b0;
         cfg_err <= hs && !div_ok;
         if (state == S_IDLE) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            if (hs && div_ok) cur_div <= cfg_div;
            if (en) state <= S_RUN;
         end else begin
            if (terminal) begin
               cnt     <= '0;
               clk_out <= !clk_out;
               tick    <= !clk_out;
            end else begin
               cnt <= cnt + 1'b1;
            end
            case (state)
               S_RUN: begin
                  if (hs && div_ok) begin
                     pend_div <= cfg_div;
                     state    <= S_PEND;
                  end else if (!en) begin
                     // Dropping en exactly on the falling edge already completes the period.
                     state <= boundary ? S_IDLE : S_STOP;
                  end
               end
               S_STOP: begin
                  if (en) state <= S_RUN;
                  else if (boundary) state <= S_IDLE;
               end
               S_PEND: begin
                  if (boundary) begin
                     cur_div  <= pend_div;
                     pend_div <= '0;
                     state    <= en ? S_RUN : S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/clk_div_controller.md
CLK_DIV_CONTROLLER -- requirements
Module: clk_div_controller

Interface
REQ-001 SHALL have parameter DEF_DIV, default 4, meaning the full-period divisor loaded at reset.
REQ-002 SHALL have parameter DIV_W, default 8, meaning the width of the divisor path.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port en, input, 1, run request for the divided clock.
REQ-006 SHALL have port cfg_valid, input, 1, new divisor offered.
REQ-007 SHALL have port cfg_div, input, DIV_W, requested full-period divisor in clk cycles.
REQ-008 SHALL have port cfg_ready, output, 1, controller can accept a divisor this cycle.
REQ-009 SHALL have port cfg_err, output, 1, one-cycle pulse when an accepted-handshake divisor is rejected.
REQ-010 SHALL have port clk_out, output, 1, divided clock, 50% duty.
REQ-011 SHALL have port tick, output, 1, one-cycle pulse in each cycle where clk_out goes 0->1.
REQ-012 SHALL have port busy, output, 1, high in RUN, PEND or STOP.
REQ-013 SHALL have port cur_div, output, DIV_W, divisor currently in effect.

Function
REQ-014 SHALL implement states IDLE, RUN, PEND, STOP.
REQ-015 A handshake SHALL occur on a rising clk edge where cfg_valid=1 and cfg_ready=1.
REQ-016 cfg_ready SHALL be 1 in IDLE and RUN, and 0 in PEND and STOP.
REQ-017 A divisor SHALL be valid only if it is even and >=2.
REQ-018 An invalid divisor SHALL complete the handshake, pulse cfg_err for exactly 1 cycle on the next edge, and leave cur_div and the state unchanged.
REQ-019 A valid divisor in IDLE SHALL load cur_div on the handshake edge.
REQ-020 A valid divisor in RUN SHALL be stored in a pending register, with RUN->PEND.
REQ-021 The half-period counter SHALL count 0..cur_div/2-1; at cur_div/2-1 it SHALL clear to 0 and clk_out SHALL toggle.
REQ-022 The counter SHALL use DIV_W-1 bits; there SHALL be no wrap other than the terminal clear.
REQ-023 The period boundary SHALL be the edge where the counter is at terminal and clk_out=1, i.e. clk_out falls.
REQ-024 IDLE->RUN SHALL occur on an edge with en=1; that edge SHALL clear the counter and hold clk_out=0.
REQ-025 After RUN entry, the first clk_out rise and tick SHALL come cur_div/2 edges later.
REQ-026 PEND SHALL keep dividing with the old cur_div until the period boundary.
REQ-027 At that boundary in PEND, cur_div SHALL take the pending value, the counter SHALL clear, and PEND->RUN (or ->IDLE if en=0).
REQ-028 en=0 in RUN SHALL give RUN->STOP.
REQ-029 STOP SHALL finish the current period and go STOP->IDLE at the boundary, with clk_out=0.
REQ-030 STOP with en=1 again SHALL return to RUN without a glitch or phase change.
REQ-031 en=0 in PEND SHALL keep the state PEND; at the boundary the new divisor SHALL be applied and the state SHALL go to IDLE.
REQ-032 In IDLE, clk_out and tick SHALL be 0 and the counter SHALL hold 0.
REQ-033 clk_out SHALL never have a high or low phase shorter than min(old,new)/2 cycles.
REQ-034 tick SHALL be registered and coincide with the clk_out 0->1 transition cycle.
REQ-035 cfg_valid while cfg_ready=0 SHALL be ignored, with no error pulse.

Reset
REQ-036 rst=1 SHALL asynchronously force state IDLE, counter 0, clk_out 0, tick 0, cfg_err 0, busy 0, cur_div=DEF_DIV, and pending cleared.
REQ-037 cfg_ready SHALL read 1 immediately after reset release.
REQ-038 Reset mid-period or in PEND SHALL discard the pending divisor; the first edge after release SHALL behave as IDLE.

Verification
REQ-039 Reset, en=1, DEF_DIV=4 -> clk_out 2 high / 2 low; first tick 2 edges after RUN entry; busy=1.
REQ-040 IDLE, cfg_div=230 -> cur_div=230 next cycle; en=1 -> clk_out period 230 cycles, 115 high.
REQ-041 RUN at div 160, cfg_div=168 mid high-phase -> cfg_ready=0; the current period completes at 160; the next period is 168; cur_div changes at the falling edge.
REQ-042 cfg_div=7, then cfg_div=0 -> one cfg_err pulse each; cur_div unchanged; clk_out phase undisturbed.
REQ-043 en dropped 1 cycle after a rise at div 4 -> clk_out stays high 2 cycles, falls, state IDLE, busy=0; no extra tick.
REQ-044 rst asserted in PEND mid-high-phase -> clk_out=0 immediately; after release cur_div=DEF_DIV and the pending value is lost.
